// File: rtl/display_scan_ctrl.sv
// Scans the two road countdown timers onto one shared digit-code bus with active-low anodes.
// A per-slot dead time avoids ghosting; new timer values take effect only at frame boundaries.
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] cnt_a,
  input  logic [6:0] cnt_b,
  input  logic       upd,
  input  logic       disp_en,
  output logic       upd_ack,
  output logic       frame,
  output logic [3:0] dig_code,
  output logic [3:0] an
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0]   r_presc;
  logic [1:0]      r_sel;
  logic [1:0][6:0] r_stage;
  logic [1:0][6:0] r_shadow;
  logic            r_pend;
  logic            r_ack;
  logic            r_frame;
  logic [3:0]      r_an;
  logic [3:0]      r_code;

  logic            w_tick;
  logic            w_boundary;
  logic            w_blank;
  logic [3:0]      w_ones [2];
  logic [3:0]      w_tens_code [2];
  logic [3:0]      w_slot_code;

  assign w_tick     = (r_presc == PW'(SCAN_DIV - 1));
  assign w_boundary = w_tick && (r_sel == 2'd3);
  assign w_blank    = (r_presc < PW'(BLANK_CYC)) || !disp_en;

  // Per road: clamp to two digits, split, and optionally blank a leading zero.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_road
      logic [6:0] w_v;
      logic [3:0] w_tens;
      assign w_v            = (r_shadow[gi] > 7'd99) ? 7'd99 : r_shadow[gi];
      assign w_ones[gi]     = 4'(w_v % 7'd10);
      assign w_tens         = 4'(w_v / 7'd10);
      assign w_tens_code[gi] = (BLANK_LZ && (w_tens == 4'd0)) ? 4'd10 : w_tens;
    end
  endgenerate

  always_comb begin
    w_slot_code = 4'd10;
    case (r_sel)
      2'd0: w_slot_code = w_ones[0];
      2'd1: w_slot_code = w_tens_code[0];
      2'd2: w_slot_code = w_ones[1];
      2'd3: w_slot_code = w_tens_code[1];
      default: w_slot_code = 4'd10;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_sel   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_sel <= r_sel + 2'd1;
    end
  end

  // Staging collects the latest request; shadow changes only at the frame wrap.
  // An update on the wrap cycle itself bypasses staging so it is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage  <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_ack    <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      if (upd) r_stage <= {cnt_b, cnt_a};
      r_frame <= w_boundary;
      r_ack   <= w_boundary && (upd || r_pend);
      if (w_boundary) begin
        r_pend <= 1'b0;
        if (upd)         r_shadow <= {cnt_b, cnt_a};
        else if (r_pend) r_shadow <= r_stage;
      end else if (upd) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an   <= 4'b1111;
      r_code <= 4'd10;
    end else if (w_blank) begin
      r_an   <= 4'b1111;
      r_code <= 4'd10;
    end else begin
      r_an   <= ~(4'b0001 << r_sel);
      r_code <= w_slot_code;
    end
  end

  assign upd_ack  = r_ack;
  assign frame    = r_frame;
  assign an       = r_an;
  assign dig_code = r_code;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus randomized traffic
// checked against a frame/slot-arithmetic reference model.
module tb_display_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] cnt_a = '0;
  logic [6:0] cnt_b = '0;
  logic       upd = 1'b0;
  logic       disp_en = 1'b1;
  logic       upd_ack;
  logic       frame;
  logic [3:0] dig_code;
  logic [3:0] an;

  always #5 clk = ~clk;

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_a(cnt_a), .cnt_b(cnt_b), .upd(upd),
    .disp_en(disp_en), .upd_ack(upd_ack), .frame(frame), .dig_code(dig_code), .an(an)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time since reset release, plus the logical value registers.
  int t = 0;
  int m_sh_a = 0, m_sh_b = 0, m_st_a = 0, m_st_b = 0;
  bit m_pend = 1'b0;
  logic [3:0] exp_an = 4'hF, exp_dig = 4'd10;
  logic exp_ack = 1'b0, exp_frame = 1'b0;

  int ack_seen = 0;
  int frame_seen = 0;
  int rec [4];
  int blanks;
  int multi_low;

  function automatic int slot_code(int slot, int a, int b);
    int v;
    v = (slot < 2) ? a : b;
    if (v > 99) v = 99;
    if (slot % 2 == 0) return v % 10;
    return (v / 10 == 0) ? 10 : v / 10;
  endfunction

  task automatic cycle();
    int ph, sl;
    bit bnd;
    @(posedge clk);
    if (!rst_n) begin
      t = 0; m_sh_a = 0; m_sh_b = 0; m_st_a = 0; m_st_b = 0; m_pend = 1'b0;
      exp_an = 4'hF; exp_dig = 4'd10; exp_ack = 1'b0; exp_frame = 1'b0;
    end else begin
      ph  = t % SD;
      sl  = (t / SD) % 4;
      bnd = (t % FR == FR - 1);
      exp_an  = 4'hF;
      exp_dig = 4'd10;
      if (ph >= BC && disp_en) begin
        exp_an[sl] = 1'b0;
        exp_dig    = 4'(slot_code(sl, m_sh_a, m_sh_b));
      end
      exp_frame = bnd;
      exp_ack   = bnd && (m_pend || upd);
      if (bnd) begin
        if (upd) begin m_sh_a = cnt_a; m_sh_b = cnt_b; end
        else if (m_pend) begin m_sh_a = m_st_a; m_sh_b = m_st_b; end
        m_pend = 1'b0;
      end else if (upd) begin
        m_st_a = cnt_a; m_st_b = cnt_b; m_pend = 1'b1;
      end
      t++;
    end
    #1;
    if (upd_ack === 1'b1) ack_seen++;
    if (frame === 1'b1) frame_seen++;
  endtask

  // Advance (unchecked) until the model time within the frame equals ph.
  task automatic align(int ph);
    for (int i = 0; i < FR && (t % FR) != ph; i++) cycle();
  endtask

  // Runs one frame, recording the code shown under each anode and the blank count.
  task automatic record_frame();
    blanks = 0; multi_low = 0;
    for (int s = 0; s < 4; s++) rec[s] = -1;
    for (int i = 0; i < FR; i++) begin
      cycle();
      if (an == 4'hF) blanks++;
      else if ($countones(~an) > 1) multi_low++;
      else for (int s = 0; s < 4; s++) if (an[s] == 1'b0) rec[s] = int'(dig_code);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(); cycle();
    n_vec++;
    if (an !== 4'hF || dig_code !== 4'd10 || upd_ack !== 1'b0 || frame !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state an=%b dig=%0d ack=%b frame=%b want 1111/10/0/0", an, dig_code, upd_ack, frame);
    end
    rst_n = 1'b1;
    frame_seen = 0;
    for (int i = 0; i < 2 * FR + 6; i++) begin
      cycle();
      n_vec++;
      if (frame !== ((i == FR - 1 || i == 2 * FR - 1) ? 1'b1 : 1'b0) || an !== exp_an || dig_code !== exp_dig) begin
        n_err++;
        $display("FAIL reset_run cyc=%0d frame=%b an=%b/%b dig=%0d/%0d", i, frame, an, exp_an, dig_code, exp_dig);
      end
    end
    n_vec++;
    if (frame_seen != 2) begin
      n_err++;
      $display("FAIL reset_frames got %0d want 2", frame_seen);
    end
  endtask

  task automatic test_update();
    align(10);
    cnt_a = 7'd45; cnt_b = 7'd7; upd = 1'b1;
    cycle();
    upd = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < FR && ack_seen == 0; i++) begin
      cycle();
      n_vec++;
      if (upd_ack !== exp_ack || frame !== exp_frame || an !== exp_an || dig_code !== exp_dig) begin
        n_err++;
        $display("FAIL update_wait cyc=%0d ack=%b/%b an=%b/%b dig=%0d/%0d", i, upd_ack, exp_ack, an, exp_an, dig_code, exp_dig);
      end
    end
    n_vec++;
    if (ack_seen != 1 || t % FR != 0) begin
      n_err++;
      $display("FAIL update_ack acks=%0d at_phase=%0d want 1 at 0", ack_seen, t % FR);
    end
    record_frame();
    n_vec++;
    if (rec[0] != 5 || rec[1] != 4 || rec[2] != 7 || rec[3] != 10 || blanks != 4 * BC || multi_low != 0) begin
      n_err++;
      $display("FAIL update_frame got %0d %0d %0d %0d blanks=%0d multi=%0d want 5 4 7 10 blanks=%0d", rec[0], rec[1], rec[2], rec[3], blanks, multi_low, 4 * BC);
    end
  endtask

  task automatic test_clamp();
    align(4);
    cnt_a = 7'd120; cnt_b = 7'd0; upd = 1'b1;
    cycle();
    upd = 1'b0;
    align(0);
    record_frame();
    n_vec++;
    if (rec[0] != 9 || rec[1] != 9 || rec[2] != 0 || rec[3] != 10) begin
      n_err++;
      $display("FAIL clamp_zero got %0d %0d %0d %0d want 9 9 0 10", rec[0], rec[1], rec[2], rec[3]);
    end
  endtask

  task automatic test_coalesce();
    align(3);
    cnt_a = 7'd12; cnt_b = 7'd12; upd = 1'b1;
    cycle();
    upd = 1'b0;
    cycle(); cycle();
    cnt_a = 7'd34; cnt_b = 7'd34; upd = 1'b1;
    cycle();
    upd = 1'b0;
    ack_seen = 0;
    align(0);
    record_frame();
    n_vec++;
    if (ack_seen != 1 || rec[0] != 4 || rec[1] != 3 || rec[2] != 4 || rec[3] != 3) begin
      n_err++;
      $display("FAIL coalesce acks=%0d got %0d %0d %0d %0d want 1 ack, 4 3 4 3", ack_seen, rec[0], rec[1], rec[2], rec[3]);
    end
  endtask

  task automatic test_bypass();
    align(FR - 1);
    cnt_a = 7'd63; cnt_b = 7'd88; upd = 1'b1;
    cycle();
    upd = 1'b0;
    n_vec++;
    if (upd_ack !== 1'b1 || frame !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_ack ack=%b frame=%b want 1/1", upd_ack, frame);
    end
    record_frame();
    n_vec++;
    if (rec[0] != 3 || rec[1] != 6 || rec[2] != 8 || rec[3] != 8) begin
      n_err++;
      $display("FAIL bypass_frame got %0d %0d %0d %0d want 3 6 8 8", rec[0], rec[1], rec[2], rec[3]);
    end
  endtask

  task automatic test_disp_en();
    align(13);
    disp_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_vec++;
      if (an !== 4'hF || dig_code !== 4'd10 || frame !== exp_frame) begin
        n_err++;
        $display("FAIL disp_off cyc=%0d an=%b dig=%0d frame=%b/%b want 1111/10", i, an, dig_code, frame, exp_frame);
      end
    end
    disp_en = 1'b1;
    for (int i = 0; i < FR + 8; i++) begin
      cycle();
      n_vec++;
      if (an !== exp_an || dig_code !== exp_dig || frame !== exp_frame) begin
        n_err++;
        $display("FAIL disp_resume cyc=%0d an=%b/%b dig=%0d/%0d frame=%b/%b", i, an, exp_an, dig_code, exp_dig, frame, exp_frame);
      end
    end
  endtask

  task automatic test_reset_midframe();
    align(5);
    cnt_a = 7'd77; cnt_b = 7'd77; upd = 1'b1;
    cycle();
    upd = 1'b0;
    cycle(); cycle();
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    ack_seen = 0;
    record_frame();
    cycle();
    n_vec++;
    if (ack_seen != 0 || rec[0] != 0 || rec[1] != 10 || rec[2] != 0 || rec[3] != 10) begin
      n_err++;
      $display("FAIL reset_mid acks=%0d got %0d %0d %0d %0d want 0 acks, 0 10 0 10", ack_seen, rec[0], rec[1], rec[2], rec[3]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      upd   = ($urandom_range(5) == 0);
      cnt_a = 7'($urandom_range(127));
      cnt_b = 7'($urandom_range(127));
      if ($urandom_range(19) == 0) disp_en = ~disp_en;
      rst_n = ($urandom_range(299) != 0);
      cycle();
      n_vec++;
      if (an !== exp_an || dig_code !== exp_dig || upd_ack !== exp_ack || frame !== exp_frame || $countones(~an) > 1) begin
        n_err++;
        $display("FAIL random cyc=%0d an=%b/%b dig=%0d/%0d ack=%b/%b frame=%b/%b", i, an, exp_an, dig_code, exp_dig, upd_ack, exp_ack, frame, exp_frame);
      end
    end
    upd = 1'b0; rst_n = 1'b1; disp_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_update();
    test_clamp();
    test_coalesce();
    test_bypass();
    test_disp_en();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
